// File: rtl/shift_reg_univ.sv
// shift_reg_univ: WIDTH-bit universal register. It supports hold, shift left,
// shift right, parallel load, clear and (optionally) rotate. A shift counter
// produces a one-cycle word_done pulse once every WIDTH shift/rotate ops.
//
// Build option:
//   SHIFT_REG_UNIV_ROTATE_EN - when defined, modes 101/110 rotate left/right.
//                              When undefined, they behave as hold and no
//                              rotate logic is built.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (overrides en and mode)
//   en           clock enable; 0 freezes q and shift_cnt
//   mode         3-bit operation select
//   d            parallel load data
//   ser_in_lsb   bit entering q[0] on shift left
//   ser_in_msb   bit entering q[WIDTH-1] on shift right
//   q / q_c      register contents and its bitwise complement
//   ser_out_msb  q[WIDTH-1]
//   ser_out_lsb  q[0]
//   shift_cnt    shift/rotate ops since the last load/clear/wrap
//   word_done    one-cycle pulse after the WIDTH-th consecutive shift
module shift_reg_univ #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  localparam int               CW          = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_lsb,
  input  logic             ser_in_msb,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_c,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_LOAD  = 3'b011;
  localparam logic [2:0] MODE_CLR   = 3'b100;
  localparam logic [2:0] MODE_ROTL  = 3'b101;
  localparam logic [2:0] MODE_ROTR  = 3'b110;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_op;

  always_comb begin
    data_d   = data_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shift_op = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: ;
        MODE_SHL: begin
          data_d   = {data_q[WIDTH-2:0], ser_in_lsb};
          shift_op = 1'b1;
        end
        MODE_SHR: begin
          data_d   = {ser_in_msb, data_q[WIDTH-1:1]};
          shift_op = 1'b1;
        end
        MODE_LOAD: begin
          data_d = d;
          cnt_d  = '0;
        end
        MODE_CLR: begin
          data_d = RESET_VALUE;
          cnt_d  = '0;
        end
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        MODE_ROTL: begin
          data_d   = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          shift_op = 1'b1;
        end
        MODE_ROTR: begin
          data_d   = {data_q[0], data_q[WIDTH-1:1]};
          shift_op = 1'b1;
        end
`endif
        // Reserved code (and rotate codes when rotate is not built) hold.
        default: ;
      endcase
    end
    // The counter tracks operations, not direction; it wraps at WIDTH-1
    // even when WIDTH is not a power of two.
    if (shift_op) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VALUE;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q           = data_q;
  assign q_c         = ~data_q;
  assign ser_out_msb = data_q[WIDTH-1];
  assign ser_out_lsb = data_q[0];
  assign shift_cnt   = cnt_q;
  assign word_done   = done_q;

endmodule
